// File: rtl/reg_unit_pkg.sv
// Shared definitions for the relay register bank.
//   load_state_t    : load sequencer states
//   DEF_*           : default parameter values for reg_bank
//   SETTLE_CNT_W    : width of the settle counter (covers SETTLE_CYCLES up to 15)
package reg_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } load_state_t;

    localparam int DEF_NUM_REGS      = 4;
    localparam int DEF_WIDTH         = 8;
    localparam int DEF_SETTLE_CYCLES = 3;
    localparam int SETTLE_CNT_W      = 4;

endpackage

// File: rtl/reg_cell.sv
// One storage register of the bank.
// Ports:
//   clk : clock
//   clr : synchronous clear, wins over en
//   en  : capture enable
//   d   : data to capture
//   q   : stored value
module reg_cell #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_bank.sv
// Relay-style register bank: loads only after the load strobe and data bus
// have been stable for SETTLE_CYCLES samples, and drives a wired-OR bus.
// Ports:
//   clk     : clock
//   reset   : synchronous active-high reset
//   ld      : per-register load strobes
//   sel     : per-register drive-to-bus strobes
//   bus_in  : data bus value for loading
//   bus_out : registered OR of selected registers
//   regs_q  : all register contents, register i at [i*WIDTH +: WIDTH]
//   led_ld  : copy of ld
//   led_sel : copy of sel
//   busy    : load settling or held
//
// state  | meaning
// IDLE   | waiting for a nonzero ld; snapshot taken on the edge it is seen
// SETTLE | counting stable samples of ld/bus_in against the snapshot
// HOLD   | captured; waits for ld to return to zero
module reg_bank
    import reg_unit_pkg::*;
#(
    parameter int NUM_REGS      = DEF_NUM_REGS,
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REGS-1:0]       ld,
    input  logic [NUM_REGS-1:0]       sel,
    input  logic [WIDTH-1:0]          bus_in,
    output logic [WIDTH-1:0]          bus_out,
    output logic [NUM_REGS*WIDTH-1:0] regs_q,
    output logic [NUM_REGS-1:0]       led_ld,
    output logic [NUM_REGS-1:0]       led_sel,
    output logic                      busy
);

    localparam logic [SETTLE_CNT_W-1:0] SETTLE_TC = SETTLE_CNT_W'(SETTLE_CYCLES);

    load_state_t             state, state_nxt;
    logic [NUM_REGS-1:0]     snap_ld, snap_ld_nxt;
    logic [WIDTH-1:0]        snap_data, snap_data_nxt;
    logic [SETTLE_CNT_W-1:0] cnt, cnt_nxt;
    logic                    cap;
    logic [WIDTH-1:0]        sel_or;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            snap_ld   <= '0;
            snap_data <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            snap_ld   <= snap_ld_nxt;
            snap_data <= snap_data_nxt;
            cnt       <= cnt_nxt;
        end
    end

    // cnt counts stable samples including the snapshot sample itself, so a
    // matching SETTLE edge with cnt already at SETTLE_CYCLES is the capture edge.
    always_comb begin
        state_nxt     = state;
        snap_ld_nxt   = snap_ld;
        snap_data_nxt = snap_data;
        cnt_nxt       = cnt;
        cap           = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ld != '0) begin
                    snap_ld_nxt   = ld;
                    snap_data_nxt = bus_in;
                    cnt_nxt       = SETTLE_CNT_W'(1);
                    state_nxt     = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (ld == '0) begin
                    state_nxt = ST_IDLE;
                end else if (ld != snap_ld || bus_in != snap_data) begin
                    snap_ld_nxt   = ld;
                    snap_data_nxt = bus_in;
                    cnt_nxt       = SETTLE_CNT_W'(1);
                end else if (cnt >= SETTLE_TC) begin
                    cap       = 1'b1;
                    state_nxt = ST_HOLD;
                end else begin
                    cnt_nxt = cnt + SETTLE_CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (ld == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
        reg_cell #(.WIDTH(WIDTH)) u_cell (
            .clk (clk),
            .clr (reset),
            .en  (cap & snap_ld[i]),
            .d   (snap_data),
            .q   (regs_q[i*WIDTH +: WIDTH])
        );
    end

    // Sampled from the pre-edge register contents, so a register captured and
    // selected on the same edge shows its old value for one cycle.
    always_comb begin
        sel_or = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel[i]) begin
                sel_or = sel_or | regs_q[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_out <= '0;
        end else begin
            bus_out <= sel_or;
        end
    end

    assign led_ld  = ld;
    assign led_sel = sel;
    assign busy    = (state != ST_IDLE);

endmodule
